// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, ALUOp
// classes, datapath mux selects and the controller state encoding.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RFN  = 2'b10;
  localparam logic [1:0] ALUOP_IFN  = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // States that wait on the shared memory port's ready handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle main control: sequences fetch/decode/execute/memory/writeback
// over one memory port, with ready handshake, wait timeout and sticky trap.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5,
  parameter int unsigned IMM_ALU_EN  = 1,
  parameter int unsigned JAL_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Opcode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               Branch,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Fault,
  output logic [3:0]         CtrlState
);

  state_t             r_state;
  state_t             w_next;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [6:0]         r_op_q;
  logic               w_tmo_hit;

  // Timeout fires only once the wait has already seen MEM_TIMEOUT not-ready
  // cycles and memory is still not ready now; a ready in that cycle wins.
  assign w_tmo_hit = (MEM_TIMEOUT != 0) && !MemReady &&
                     (r_tmo_cnt == TMO_W'(MEM_TIMEOUT));

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (MemReady)       w_next = S_DECODE;
        else if (w_tmo_hit) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_IMM:            w_next = (IMM_ALU_EN != 0) ? S_EXEC_I : S_TRAP;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = (JAL_EN != 0) ? S_JAL : S_TRAP;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (r_op_q == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady)       w_next = S_MEMWB;
        else if (w_tmo_hit) w_next = S_TRAP;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR: begin
        if (MemReady)       w_next = S_FETCH;
        else if (w_tmo_hit) w_next = S_TRAP;
      end
      S_EXEC_R: w_next = S_ALUWB;
      S_EXEC_I: w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JAL:    w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register, opcode capture in DECODE, and wait-cycle counter.
  // The counter only advances while a wait state holds itself (MemReady=0);
  // any transition, including entry to a wait state, clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
      r_op_q    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= Opcode;
      if (is_wait_state(r_state) && (w_next == r_state)) begin
        if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  // Moore output decode from the current state; IRWrite/PCWrite in FETCH
  // are additionally qualified by MemReady.
  always_comb begin
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    Branch    = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_W'(ALUOP_ADD);
    Fault     = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = SRCB_IMM;
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_MEM;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_W'(ALUOP_RFN);
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_W'(ALUOP_IFN);
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_W'(ALUOP_SUB);
        Branch  = 1'b1;
        PCSrc   = 1'b1;
      end
      S_JAL: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_PC;
        PCWrite   = 1'b1;
        PCSrc     = 1'b1;
      end
      S_TRAP:  Fault = 1'b1;
      default: ;
    endcase
  end

  assign CtrlState = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (timeout 4 with all
// options enabled; timeout disabled with I-type and JAL disabled) share the
// stimulus and are compared every cycle against a behavioural model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode;
  logic       MemReady;

  logic [1:0] pcw, pcsrc, br, iord, mrd, mwr, irw, rgw, flt;
  logic [1:0] ressrc [2];
  logic [1:0] srca   [2];
  logic [1:0] srcb   [2];
  logic [1:0] aluop  [2];
  logic [3:0] cst    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(4), .TMO_W(5),
                       .IMM_ALU_EN(1), .JAL_EN(1)) dut_a (
    .clk(clk), .rst(rst), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(pcw[0]), .PCSrc(pcsrc[0]), .Branch(br[0]), .IorD(iord[0]),
    .MemRead(mrd[0]), .MemWrite(mwr[0]), .IRWrite(irw[0]), .RegWrite(rgw[0]),
    .ResultSrc(ressrc[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
    .ALUOp(aluop[0]), .Fault(flt[0]), .CtrlState(cst[0]));

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(0), .TMO_W(5),
                       .IMM_ALU_EN(0), .JAL_EN(0)) dut_b (
    .clk(clk), .rst(rst), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(pcw[1]), .PCSrc(pcsrc[1]), .Branch(br[1]), .IorD(iord[1]),
    .MemRead(mrd[1]), .MemWrite(mwr[1]), .IRWrite(irw[1]), .RegWrite(rgw[1]),
    .ResultSrc(ressrc[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
    .ALUOp(aluop[1]), .Fault(flt[1]), .CtrlState(cst[1]));

  // ---------------- behavioural model ----------------
  int        m_tmo   [2] = '{4, 0};
  bit        m_immen [2] = '{1'b1, 1'b0};
  bit        m_jalen [2] = '{1'b1, 1'b0};
  int        m_st    [2];
  int        m_cnt   [2];
  logic [6:0] m_opq  [2];
  bit        m_valid = 1'b0;

  // Expected outputs {PCWrite,PCSrc,Branch,IorD,MemRead,MemWrite,IRWrite,
  // RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Fault,CtrlState} for a step.
  function automatic logic [20:0] m_out(input int s, input logic mr);
    logic pw, ps, b, id, rd, wr, ir, rw, f;
    logic [1:0] rs, sa, sb, op;
    {pw, ps, b, id, rd, wr, ir, rw, f} = '0;
    {rs, sa, sb, op} = '0;
    case (s)
      1:  begin rd = 1; sb = 2'd1; ir = mr; pw = mr; end
      2:  sb = 2'd2;
      3:  begin sa = 2'd1; sb = 2'd2; end
      4:  begin id = 1; rd = 1; end
      5:  begin rw = 1; rs = 2'd1; end
      6:  begin id = 1; wr = 1; end
      7:  begin sa = 2'd1; op = 2'd2; end
      8:  begin sa = 2'd1; sb = 2'd2; op = 2'd3; end
      9:  rw = 1;
      10: begin sa = 2'd1; op = 2'd1; b = 1; ps = 1; end
      11: begin rw = 1; rs = 2'd2; pw = 1; ps = 1; end
      12: f = 1;
      default: ;
    endcase
    return {pw, ps, b, id, rd, wr, ir, rw, rs, sa, sb, op, f, 4'(s)};
  endfunction

  function automatic logic [20:0] got_vec(input int i);
    return {pcw[i], pcsrc[i], br[i], iord[i], mrd[i], mwr[i], irw[i], rgw[i],
            ressrc[i], srca[i], srcb[i], aluop[i], flt[i], cst[i]};
  endfunction

  // Advance the model by one clock using the instruction-level rules.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = 0; m_cnt[i] = 0; m_opq[i] = '0;
      end else if (m_valid) begin
        if (m_st[i] == 1 || m_st[i] == 4 || m_st[i] == 6) begin
          if (MemReady) begin
            m_st[i]  = (m_st[i] == 1) ? 2 : (m_st[i] == 4) ? 5 : 1;
            m_cnt[i] = 0;
          end else if (m_tmo[i] != 0 && m_cnt[i] >= m_tmo[i]) begin
            m_st[i] = 12; m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end else begin
          m_cnt[i] = 0;
          case (m_st[i])
            0: m_st[i] = 1;
            2: begin
              m_opq[i] = Opcode;
              if (Opcode == 7'b0000011 || Opcode == 7'b0100011) m_st[i] = 3;
              else if (Opcode == 7'b0110011) m_st[i] = 7;
              else if (Opcode == 7'b0010011 && m_immen[i]) m_st[i] = 8;
              else if (Opcode == 7'b1100011) m_st[i] = 10;
              else if (Opcode == 7'b1101111 && m_jalen[i]) m_st[i] = 11;
              else m_st[i] = 12;
            end
            3: m_st[i] = (m_opq[i] == 7'b0000011) ? 4 : 6;
            5, 9, 10, 11: m_st[i] = 1;
            7, 8: m_st[i] = 9;
            default: ;
          endcase
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle comparison, mid-cycle after inputs have settled.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [20:0] e, g;
        e = m_out(m_st[i], MemReady);
        g = got_vec(i);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t got=%h expected=%h", i, $time, g, e);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic mr);
    rst = r; Opcode = op; MemReady = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input logic r, input logic [6:0] op, input logic mr);
    drive(r, op, mr);
    tick();
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] IM = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] XX = 7'b1111111;

  initial begin
    drive(1'b1, 7'd0, 1'b0);
    step(1, 7'd0, 0);
    step(1, 7'd0, 0);
    lit("reset_state", cst[0], 0);
    lit("reset_fault", flt[0], 0);

    // R-type: 0,1,2,7,9,1
    step(0, R, 1); lit("r_fetch", cst[0], 1);
    step(0, R, 1); lit("r_decode", cst[0], 2);
    step(0, R, 1); lit("r_exec", cst[0], 7); lit("r_aluop", aluop[0], 2);
    step(0, R, 1); lit("r_aluwb", cst[0], 9); lit("r_regwrite", rgw[0], 1);
    step(0, R, 1); lit("r_back_fetch", cst[0], 1);

    // lw with 3 wait cycles; Opcode changes after DECODE to exercise op_q
    step(0, LW, 1); lit("lw_decode", cst[0], 2);
    step(0, LW, 1); lit("lw_memadr", cst[0], 3);
    step(0, SW, 0); lit("lw_memrd", cst[0], 4);
    step(0, SW, 0);
    step(0, SW, 0);
    step(0, SW, 0); lit("lw_memrd_held", cst[0], 4); lit("lw_iord", iord[0], 1);
    step(0, SW, 1); lit("lw_memwb", cst[0], 5); lit("lw_ressrc", ressrc[0], 1);
    step(0, SW, 1); lit("lw_fetch", cst[0], 1);

    // Fetch stall: 4 not-ready cycles, then ready exactly at the timeout cycle
    repeat (4) step(0, SW, 0);
    lit("stall_state", cst[0], 1); lit("stall_irwrite", irw[0], 0);
    drive(0, SW, 1); #1;
    lit("stall_irwrite_rdy", irw[0], 1); lit("stall_pcwrite_rdy", pcw[0], 1);
    tick(); lit("stall_decode", cst[0], 2);

    // sw with memory never ready: A times out, B (no timeout) keeps waiting
    step(0, SW, 0); lit("sw_memadr", cst[0], 3);
    step(0, SW, 0); lit("sw_memwr", cst[0], 6);
    repeat (4) step(0, SW, 0);
    lit("tmo_not_yet", cst[0], 6);
    step(0, SW, 0);
    lit("tmo_trap", cst[0], 12); lit("tmo_fault", flt[0], 1);
    lit("no_tmo_wait", cst[1], 6);
    step(0, SW, 1);
    step(0, SW, 1);
    lit("fault_sticky", flt[0], 1); lit("b_recovered", cst[1], 2);
    step(1, SW, 1);
    lit("fault_cleared", flt[0], 0); lit("b_reset", cst[1], 0);

    // JAL: enabled on A, illegal on B
    step(0, JL, 1);
    step(0, JL, 1);
    step(0, JL, 1);
    lit("jal_state", cst[0], 11); lit("jal_pcwrite", pcw[0], 1);
    lit("jal_ressrc", ressrc[0], 2); lit("jal_disabled_trap", cst[1], 12);
    step(0, JL, 1); lit("jal_fetch", cst[0], 1);

    // I-type ALU then beq on A
    step(0, IM, 1);
    step(0, IM, 1); lit("imm_exec", cst[0], 8); lit("imm_aluop", aluop[0], 3);
    step(0, IM, 1); lit("imm_aluwb", cst[0], 9);
    step(0, BQ, 1);
    step(0, BQ, 1);
    step(0, BQ, 1); lit("beq_state", cst[0], 10); lit("beq_branch", br[0], 1);
    step(0, XX, 1); lit("beq_fetch", cst[0], 1);

    // Illegal opcode
    step(0, XX, 1);
    step(0, XX, 1); lit("illegal_trap", cst[0], 12);
    step(1, XX, 1);

    // Reset mid-instruction in MEMWR
    step(0, SW, 1);
    step(0, SW, 1);
    step(0, SW, 1);
    step(0, SW, 0); lit("mid_memwr", cst[0], 6); lit("mid_memwrite", mwr[0], 1);
    step(1, SW, 0);
    lit("mid_rst_idle", cst[0], 0); lit("mid_rst_memwrite", mwr[0], 0);
    step(1, SW, 0);
    step(0, R, 1);
    step(0, R, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
